// File: rtl/handshake_muli_pipe.sv
// Elastic pipelined multiplier: joins lhs/rhs tokens and emits the low DATA_WIDTH
// bits of their product LATENCY stages later; the whole pipe stalls on backpressure.
module handshake_muli_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] lhs,
  input  logic                  lhs_valid,
  output logic                  lhs_ready,
  input  logic [DATA_WIDTH-1:0] rhs,
  input  logic                  rhs_valid,
  output logic                  rhs_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  logic en;
  logic accept;

  assign en        = !result_valid || result_ready;
  assign lhs_ready = rhs_valid && en;
  assign rhs_ready = lhs_valid && en;
  assign accept    = lhs_valid && rhs_valid && en;

  if (LATENCY == 1) begin : g_single
    logic [DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] data;
    logic                  vld;

    assign prod = lhs * rhs;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld  <= 1'b0;
        data <= '0;
      end else if (en) begin
        vld  <= accept;
        data <= prod;
      end
    end

    assign result       = data;
    assign result_valid = vld;
  end else begin : g_multi
    localparam int unsigned PD = LATENCY - 1;

    // Stage 1 holds the operands; the multiply sits between stage 1 and stage 2,
    // later stages only shift the product forward.
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] pipe [PD];
    logic [LATENCY-1:0]    vld;

    assign prod = op_a * op_b;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        op_a <= '0;
        op_b <= '0;
        vld  <= '0;
        for (int unsigned i = 0; i < PD; i++) begin
          pipe[i] <= '0;
        end
      end else if (en) begin
        vld <= {vld[LATENCY-2:0], accept};
        if (accept) begin
          op_a <= lhs;
          op_b <= rhs;
        end
        pipe[0] <= prod;
        for (int unsigned i = 1; i < PD; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
    end

    assign result       = pipe[PD-1];
    assign result_valid = vld[LATENCY-1];
  end

endmodule

// File: tb/tb_handshake_muli_pipe.sv
// Directed bench for handshake_muli_pipe (DATA_WIDTH=32, LATENCY=4) with a
// queue scoreboard filled on input handshakes and drained on output handshakes.
module tb_handshake_muli_pipe;

  localparam int DW  = 32;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] lhs, rhs, result;
  logic          lhs_valid, rhs_valid, result_ready;
  logic          lhs_ready, rhs_ready, result_valid;

  handshake_muli_pipe #(.DATA_WIDTH(DW), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .lhs          (lhs),
    .lhs_valid    (lhs_valid),
    .lhs_ready    (lhs_ready),
    .rhs          (rhs),
    .rhs_valid    (rhs_valid),
    .rhs_ready    (rhs_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] v;
    int            due;
    bit            lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   pops = 0;
  int   accepts = 0;
  bit   lat_check = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: handshakes seen at the negedge are the ones taken at the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (result_valid && result_ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("result", 64'(result), 64'(e.v));
          if (e.lat) chk("latency", 64'(cyc), 64'(e.due));
          pops++;
        end
      end
      if (lhs_valid && rhs_valid) chk("ready_pair", 64'(rhs_ready), 64'(lhs_ready));
      if (lhs_valid && rhs_valid && lhs_ready) begin
        exp_t e;
        logic [2*DW-1:0] full;
        full  = {{DW{1'b0}}, lhs} * {{DW{1'b0}}, rhs};
        e.v   = full[DW-1:0];
        e.due = cyc + LAT;
        e.lat = lat_check;
        sb.push_back(e);
        accepts++;
        chk("in_flight", 64'(sb.size() <= LAT), 64'd1);
      end
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit ok;
    ok = 1'b0;
    lhs = a; rhs = b; lhs_valid = 1'b1; rhs_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = lhs_ready;
      @(posedge clk); #1;
    end
    chk("send_timeout", 64'(ok), 64'd1);
    lhs_valid = 1'b0; rhs_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget);
    @(negedge clk);
    for (int i = 0; i < budget && !result_valid; i++) @(negedge clk);
    chk("out_timeout", 64'(result_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, a0, k;
    bit prev_stall;
    logic [DW-1:0] held;

    rst = 1'b1; result_ready = 1'b1;
    lhs = '0; rhs = '0; lhs_valid = 1'b0; rhs_valid = 1'b0;

    // Reset with random inputs
    repeat (3) begin
      lhs = $urandom; rhs = $urandom;
      lhs_valid = 1'($urandom_range(0, 1)); rhs_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_valid", 64'(result_valid), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
    end
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    #2 rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("idle_valid", 64'(result_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Single token 7*6
    lat_check = 1'b1;
    send(32'd7, 32'd6);
    wait_out(10);
    chk("single_result", 64'(result), 64'd42);
    @(negedge clk);
    chk("single_one_cycle", 64'(result_valid), 64'd0);
    @(posedge clk); #1;

    // Streaming i*(i+1)
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      lhs = 32'(i); rhs = 32'(i + 1); lhs_valid = 1'b1; rhs_valid = 1'b1;
      @(posedge clk); #1;
    end
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("stream_count", 64'(pops - p0), 64'd8);
    @(posedge clk); #1;
    lat_check = 1'b0;

    // Backpressure: result_ready low for steps 6..15
    p0 = pops; k = 0; prev_stall = 1'b0; held = '0;
    for (int j = 0; j < 40; j++) begin
      result_ready = !(j >= 6 && j <= 15);
      lhs_valid = (k < 12); rhs_valid = (k < 12);
      lhs = 32'(k * 3 + 5); rhs = 32'(k * 7 + 1);
      @(negedge clk);
      if (result_valid && !result_ready) begin
        chk("stall_lhs_ready", 64'(lhs_ready), 64'd0);
        chk("stall_rhs_ready", 64'(rhs_ready), 64'd0);
        if (prev_stall) chk("stall_hold", 64'(result), 64'(held));
        held = result;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (lhs_valid && rhs_valid && lhs_ready) k++;
      @(posedge clk); #1;
    end
    lhs_valid = 1'b0; rhs_valid = 1'b0; result_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_sent", 64'(k), 64'd12);
    chk("bp_count", 64'(pops - p0), 64'd12);
    chk("bp_drained", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;

    // Join: lone lhs is never consumed
    a0 = accepts;
    lhs = 32'd9; lhs_valid = 1'b1; rhs = 32'd11; rhs_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("join_lhs_ready", 64'(lhs_ready), 64'd0);
      chk("join_rhs_ready", 64'(rhs_ready), 64'd1);
      @(posedge clk); #1;
    end
    chk("join_no_accept", 64'(accepts - a0), 64'd0);
    rhs_valid = 1'b1;
    @(negedge clk);
    chk("join_ready", 64'(lhs_ready), 64'd1);
    @(posedge clk); #1;
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    wait_out(10);
    chk("join_result", 64'(result), 64'd99);
    chk("join_single_accept", 64'(accepts - a0), 64'd1);
    @(posedge clk); #1;

    // Modular wrap
    lat_check = 1'b1;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out(10);
    chk("wrap_ones", 64'(result), 64'h1);
    @(posedge clk); #1;
    send(32'h0001_0000, 32'h0001_0000);
    wait_out(10);
    chk("wrap_zero", 64'(result), 64'h0);
    @(posedge clk); #1;
    lat_check = 1'b0;

    // Reset with three tokens in flight
    result_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lhs = 32'(i + 2); rhs = 32'(i + 5); lhs_valid = 1'b1; rhs_valid = 1'b1;
      @(posedge clk); #1;
    end
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_valid", 64'(result_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(result_valid), 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    sb.delete();
    #1 rst = 1'b0;
    result_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("post_rst_valid", 64'(result_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
